// File: rtl/spi_pkg.sv
// Shared constants, state encoding and payload types for the SPI master transmitter.
package spi_pkg;

    localparam int unsigned SPI_BITS     = 8;
    localparam int unsigned HALF_DIV_MIN = 4;
    localparam int unsigned HALF_DIV_MAX = 255;
    localparam int unsigned HALF_DIV_DEF = 4;
    localparam int unsigned GAP_CYC_MIN  = 4;
    localparam int unsigned GAP_CYC_DEF  = 8;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned BITCNT_W     = $clog2(SPI_BITS);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_HIGH = 3'd2,
        ST_WAIT = 3'd3,
        ST_HOLD = 3'd4,
        ST_GAP  = 3'd5
    } spi_state_e;

    // Latched byte: MSB goes straight to MOSI, the rest waits here.
    typedef struct packed {
        logic [SPI_BITS-2:0] rest;
        logic                last;
    } tx_word_t;

    function automatic logic half_div_ok(input int unsigned hd);
        return (hd >= HALF_DIV_MIN) && (hd <= HALF_DIV_MAX);
    endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// Byte stream into the SPI master: valid/ready with an end-of-frame marker.
interface spi_master_tx_if;
    import spi_pkg::*;

    logic [SPI_BITS-1:0] tx_data;
    logic                tx_valid;
    logic                tx_last;
    logic                tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/spi_half_tick.sv
// Clearable cycle counter; tick_c marks the last cycle of a limit-long interval.
module spi_half_tick
    import spi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             tick_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick_c = (cnt == (limit - CNT_W'(1)));

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master, MSB first, frames bytes from a valid/ready stream under one SSEL window.
// Define SPI_MASTER_RX_EN to capture MISO into rx_data/rx_valid.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int unsigned HALF_DIV = HALF_DIV_DEF,
    parameter int unsigned GAP_CYC  = GAP_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_master_tx_if.slave      tx,
    output logic                busy,
    output logic                SCK,
    output logic                MOSI,
    output logic                SSEL,
    input  logic                MISO,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_valid
);

    if (!half_div_ok(HALF_DIV)) begin : g_bad_half_div
        $error("spi_master_tx: HALF_DIV=%0d outside %0d..%0d", HALF_DIV, HALF_DIV_MIN, HALF_DIV_MAX);
    end
    if (GAP_CYC < GAP_CYC_MIN || GAP_CYC >= (1 << CNT_W)) begin : g_bad_gap_cyc
        $error("spi_master_tx: GAP_CYC=%0d out of range", GAP_CYC);
    end

    spi_state_e            state;
    tx_word_t              word_q;
    logic [BITCNT_W-1:0]   bitcnt;
    logic                  tx_ready_q;
    logic                  accept_c;
    logic                  tick_c;
    logic                  clr_c;
    logic [CNT_W-1:0]      limit_c;

    assign tx.tx_ready = tx_ready_q;
    assign accept_c    = tx_ready_q && tx.tx_valid;

    // Every state change restarts the interval counter.
    assign clr_c   = tick_c || accept_c;
    assign limit_c = (state == ST_GAP) ? CNT_W'(GAP_CYC) : CNT_W'(HALF_DIV);

    spi_half_tick u_half_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr_c),
        .limit  (limit_c),
        .tick_c (tick_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            word_q     <= '0;
            bitcnt     <= '0;
            tx_ready_q <= 1'b0;
            busy       <= 1'b0;
            SCK        <= 1'b0;
            MOSI       <= 1'b0;
            SSEL       <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        word_q.rest <= tx.tx_data[SPI_BITS-2:0];
                        word_q.last <= tx.tx_last;
                        bitcnt      <= BITCNT_W'(SPI_BITS - 1);
                        MOSI        <= tx.tx_data[SPI_BITS-1];
                        SSEL        <= 1'b0;
                        busy        <= 1'b1;
                        tx_ready_q  <= 1'b0;
                        state       <= ST_LOW;
                    end else begin
                        tx_ready_q  <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (tick_c) begin
                        SCK   <= 1'b1;
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tick_c) begin
                        SCK <= 1'b0;
                        // Next bit leaves on the same edge SCK falls.
                        if (bitcnt != '0) begin
                            bitcnt      <= bitcnt - BITCNT_W'(1);
                            MOSI        <= word_q.rest[SPI_BITS-2];
                            word_q.rest <= {word_q.rest[SPI_BITS-3:0], 1'b0};
                            state       <= ST_LOW;
                        end else if (word_q.last) begin
                            state       <= ST_HOLD;
                        end else begin
                            tx_ready_q  <= 1'b1;
                            state       <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (accept_c) begin
                        word_q.rest <= tx.tx_data[SPI_BITS-2:0];
                        word_q.last <= tx.tx_last;
                        bitcnt      <= BITCNT_W'(SPI_BITS - 1);
                        MOSI        <= tx.tx_data[SPI_BITS-1];
                        tx_ready_q  <= 1'b0;
                        state       <= ST_LOW;
                    end
                end
                ST_HOLD: begin
                    if (tick_c) begin
                        SSEL  <= 1'b1;
                        MOSI  <= 1'b0;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick_c) begin
                        busy       <= 1'b0;
                        tx_ready_q <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_MASTER_RX_EN
    logic [1:0]          miso_sync;
    logic [SPI_BITS-1:0] rx_shift;

    // MISO is sampled as SCK rises; the byte is published with the final SCK fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miso_sync <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            miso_sync <= {miso_sync[0], MISO};
            rx_valid  <= 1'b0;
            if (state == ST_LOW && tick_c) begin
                rx_shift <= {rx_shift[SPI_BITS-2:0], miso_sync[1]};
            end
            if (state == ST_HIGH && tick_c && bitcnt == '0) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_miso;

    assign unused_miso = MISO;
    assign rx_data     = '0;
    assign rx_valid    = 1'b0;
`endif

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI master (mode 0: CPOL=0, CPHA=0; MSB first; 8-bit words) that drives SCK/MOSI/SSEL into the FPGA-side SPI slave receivers.
- Accepts bytes on a valid/ready stream and groups them into frames, with SSEL held low for the whole frame.
- Used for board-level loopback of the mirror display link and as the host-side driver for on-chip tests.
- Optionally captures MISO into a received byte per transfer.

Parameters:
- HALF_DIV, 4, clk cycles per SCK half-period. Legal range 4..255; values below 4 break slave 3-stage sync. Elaboration error if out of range.
- GAP_CYC, 8, minimum clk cycles SSEL stays high between frames. Must be ≥ 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_last  in  1  byte is last of frame; sampled with tx_data
- tx_ready  out  1  block accepts byte this cycle
- busy  out  1  high from accept until SSEL deasserts and GAP_CYC expires
- SCK  out  1  SPI clock, idles low
- MOSI  out  1  master data out
- SSEL  out  1  slave select, active-low
- MISO  in  1  slave data in
- rx_data  out  8  last byte captured from MISO
- rx_valid  out  1  one-cycle pulse, rx_data updated

Behaviour:
- Synchronous, active-low reset.
- Reset values: SSEL=1, SCK=0, MOSI=0, tx_ready=0, busy=0, rx_data=0, rx_valid=0; state=IDLE. First cycle after release: tx_ready=1.
- All SPI outputs are registered (glitch-free). A half-period counter (0..HALF_DIV-1) is cleared on every state entry.
- States: IDLE, LOW, HIGH, WAIT, HOLD, GAP.
- IDLE:
  - tx_ready=1.
  - On tx_valid: latch byte and tx_last, bitcnt=7.
  - Next cycle: SSEL=0, MOSI=bit7, enter LOW.
- LOW:
  - SCK=0 for HALF_DIV cycles.
  - Then SCK→1, enter HIGH.
- HIGH:
  - SCK=1 for HALF_DIV cycles.
  - Then SCK→0.
  - If bitcnt>0: bitcnt--, MOSI=next bit (same edge as SCK fall), enter LOW.
  - If bitcnt==0: byte done. Enter HOLD if last, else WAIT.
- WAIT:
  - SSEL=0, SCK=0, tx_ready=1, indefinitely.
  - On accept: load byte, MOSI=bit7, enter LOW.
  - tx_last on the new byte governs that byte only.
- HOLD:
  - SCK=0, SSEL=0 for HALF_DIV cycles.
  - Then SSEL=1, MOSI=0, enter GAP.
- GAP:
  - SSEL=1 for GAP_CYC cycles, tx_ready=0.
  - Then enter IDLE.
- tx_ready is 1 only in IDLE and WAIT. Data presented in any other state is ignored, not queued.
- Timing:
  - Exactly 8 SCK rising edges per byte; no SCK edges while SSEL=1.
  - Single-byte frame, accept at cycle 0: SSEL low at cycle 1, SSEL high at cycle 1+17·HALF_DIV.
- Reset mid-frame: outputs return to reset values on the next clk edge. SSEL rising mid-byte is legal; the slave discards the partial byte.
- tx_valid held with tx_last=0 continuously gives back-to-back bytes with a 1-cycle WAIT between them (SCK low gap = HALF_DIV+1 cycles).

Optional Feature:
- SPI_MASTER_RX_EN defined:
  - MISO passes through a 2-flop synchroniser.
  - Sampled on the clk cycle SCK rises (end of LOW), shifted MSB-first.
  - On the last HIGH→fall: rx_data updated, rx_valid pulses 1 cycle. Pulse coincides with the WAIT/HOLD entry.
- SPI_MASTER_RX_EN undefined:
  - MISO unused; rx_data tied 0, rx_valid tied 0.
  - No sampling logic synthesised.

Decomposition:
- Shared package spi_pkg:
  - state encoding constants
  - SPI_BITS=8
  - HALF_DIV_MIN=4
  - default HALF_DIV and GAP_CYC
- Sub-module spi_half_tick: loadable half-period counter, emits a tick on the last cycle. Top contains the FSM, shift register and RX capture.

Test Plan:
- Single byte 0x61, tx_last=1, HALF_DIV=4 -> MOSI at 8 SCK rises = 0,1,1,0,0,0,0,1; SSEL low 68 cycles; mirror_spi_driver loopback sets LED[0]=1 only.
- Frame 0x62,0x63,0x64 back-to-back, last on 0x64 -> one SSEL low window, 24 SCK rises; slave LED[3:1]=111; tx_ready high exactly 1 cycle between bytes.
- tx_valid asserted during HIGH/GAP -> tx_ready=0 and no byte accepted; GAP holds SSEL=1 for ≥8 cycles before next accept.
- rst_n low at bit 3 of byte 0xA5 -> next cycle SSEL=1, SCK=0, MOSI=0; after release tx_ready=1 and a fresh 0x3C transmits correctly.
- SPI_MASTER_RX_EN, slave model returns 0xC3 on MISO (changes on SCK fall) -> rx_valid single pulse, rx_data=0xC3; undefined build -> rx_valid never asserts.
- WAIT stall: tx_last=0 on 0x11, no tx_valid for 100 cycles -> SSEL stays 0, SCK stays 0, busy=1 throughout.
